gen_vectores_compuerta: RTL and testbench
=========================================

Name: gen_vectores_compuerta

Overview:
- Self-checking stimulus and response stage placed directly upstream of a combinational gate under test.
- Sweeps every N_IN-bit input combination, holds each one for a settle window, then samples the gate output.
- Compares the sampled output against an internal reference model for the selected operation.
- Reports mismatch count, first failing vector, done and pass; replaces hand-written exhaustive loops with a synthesizable, reusable block.

Parameters:
- N_IN, 2, number of gate inputs / vector width (1..8).
- SETTLE, 1, cycles each vector is held before sampling (>=1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- op  input  2  operation select, latched at start: 00 AND, 01 OR, 10 XOR, 11 NAND.
- dut_out  input  1  output of the gate under test.
- vec  output  N_IN  current stimulus vector driven to the gate.
- sample  output  1  high during the cycle in which dut_out is compared.
- expected  output  1  reference-model value for vec under the latched op.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high (level) in DONE until the next start or reset.
- err_count  output  ERR_W  mismatches in the current or last sweep, saturating.
- first_err_vec  output  N_IN  vector of the first mismatch.
- first_err_valid  output  1  first_err_vec holds a valid value.
- pass  output  1  done && err_count==0.

Behaviour:
- Reset (async, any state): state=IDLE. vec, sample, busy, done, err_count, first_err_vec, first_err_valid and pass all go to 0. The latched op goes to 00.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1 (next edge):
  - Latch op; vec=0; clear err_count, first_err_vec and first_err_valid.
  - Load the settle counter with SETTLE; go to SETTLE.
  - done drops in that same edge.
- SETTLE: decrement the counter each cycle. When it reaches 1, go to CHECK, so vec is stable for exactly SETTLE cycles before CHECK.
- CHECK (one cycle, sample=1): compare dut_out with expected.
  - On mismatch: err_count += 1, saturating at 2^ERR_W-1.
  - On mismatch with first_err_valid=0: first_err_vec=vec and first_err_valid=1.
  - If vec == all-ones: go to DONE, and vec holds its final value.
  - Else: vec += 1, reload the counter with SETTLE, go to SETTLE.
- Sweep length: exactly 2^N_IN*(SETTLE+1) cycles from the start edge to the edge where done rises.
- Expected (combinational from latched op and vec):
  - AND = &vec, OR = |vec, XOR = ^vec, NAND = ~&vec.
- start while busy is ignored. op changes while busy are ignored.
- start and done coincident in the DONE state: a new sweep begins and counters clear.
- Reset mid-sweep: the sweep is aborted immediately, no partial results are kept, and the block waits for a new start.
- vec never wraps past all-ones within a sweep.
- dut_out is sampled only in CHECK; its value in any other cycle is don't-care.

Decomposition:
- Shared package:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NAND=2'b11;
  - state encoding constants S_IDLE, S_SETTLE, S_CHECK, S_DONE.
- One sub-module, modelo_compuerta (params N_IN; inputs op, vec; output expected), is the pure combinational reference model. It is reusable by later gate checkers.
- FSM, counters and error capture stay in the top module.

Test Plan:
- N_IN=2, SETTLE=1, op=AND, dut_out=&vec: pulse start -> vec 0,1,2,3, four sample pulses, done at cycle 8, err_count=0, pass=1, first_err_valid=0.
- N_IN=2, op=OR, dut_out tied to 0: sweep -> err_count=3, first_err_vec=2'b01, first_err_valid=1, pass=0.
- N_IN=3, ERR_W=2, op=XOR, dut_out tied to 0: sweep -> 4 mismatches, err_count saturates at 3, first_err_vec=3'b001.
- SETTLE=3, N_IN=2, op=NAND with a correct DUT: each vec held 3 cycles before sample, done at cycle 16; a start pulsed at cycle 5 has no effect.
- Reset asserted during vec=2 -> all outputs 0 asynchronously, state IDLE. A new start with op=AND completes a full clean 8-cycle sweep with pass=1.
- From DONE with err_count=3, pulse start with a correct DUT -> counters clear on the start edge, sweep reruns, pass=1.

Source files
------------

// File: rtl/gen_vectores_compuerta_pkg.sv
// Shared definitions for the exhaustive gate-vector checker:
// operation encodings and FSM state encoding.
package gen_vectores_compuerta_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/modelo_compuerta.sv
// Purely combinational reference model of a reduction gate.
// Kept separate so later gate checkers can reuse it unchanged.
module modelo_compuerta
  import gen_vectores_compuerta_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [1:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  // Reduce the stimulus vector according to the selected operation
  always_comb begin
    expected = 1'b0;
    case (op)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_NAND: expected = ~&vec;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gen_vectores_compuerta.sv
// Exhaustive stimulus generator and response checker for a combinational
// gate. Sweeps all N_IN-bit vectors, holds each for SETTLE cycles, samples
// the gate output for one cycle and counts mismatches against the model.
module gen_vectores_compuerta
  import gen_vectores_compuerta_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             dut_out,
  output logic [N_IN-1:0]  vec,
  output logic             sample,
  output logic             expected,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid,
  output logic             pass
);

  // Counter must hold the value SETTLE itself; SETTLE >= 1 keeps CNT_W >= 1
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       op_q;
  logic             mismatch;

  modelo_compuerta #(
    .N_IN(N_IN)
  ) u_modelo (
    .op       (op_q),
    .vec      (vec),
    .expected (expected)
  );

  assign mismatch = (dut_out != expected);

  // Status outputs decode directly from the state register, so they are
  // glitch-free and clear together with the state on reset
  assign sample = (state == S_CHECK);
  assign busy   = (state == S_SETTLE) || (state == S_CHECK);
  assign done   = (state == S_DONE);
  assign pass   = done && (err_count == '0);

  // Sweep FSM: vector stepping, settle timing and error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      op_q            <= OP_AND;
      vec             <= '0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q            <= op;
            vec             <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            settle_cnt      <= SETTLE_LOAD;
            state           <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - CNT_ONE;
          if (settle_cnt == CNT_ONE) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
            if (!first_err_valid) begin
              first_err_vec   <= vec;
              first_err_valid <= 1'b1;
            end
          end
          if (vec == '1) begin
            state <= S_DONE;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_vectores_compuerta.sv
// Scoreboard bench for gen_vectores_compuerta: each sweep's expected
// samples and final results are queued at stimulus time and checked by
// an independent monitor as the DUT presents them.
module tb_gen_vectores_compuerta;

  localparam int N_IN      = 3;
  localparam int SETTLE    = 2;
  localparam int ERR_W     = 3;
  localparam int NV        = 1 << N_IN;
  localparam int SWEEP_CYC = NV * (SETTLE + 1);
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             dut_out;
  logic [N_IN-1:0]  vec;
  logic             sample;
  logic             expected;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  first_err_vec;
  logic             first_err_valid;
  logic             pass;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int v;
    int e;
    int ec;
    int fv;
  } samp_t;

  typedef struct {
    int ec;
    int fvec;
    int fval;
    int pass;
  } res_t;

  samp_t samp_q[$];
  res_t  res_q[$];

  // Behaviour of the emulated gate under test for the current sweep
  logic [1:0]    sweep_op = 2'b00;
  int            mode = 0;
  logic [NV-1:0] flip_mask = '0;

  gen_vectores_compuerta #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE),
    .ERR_W (ERR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .dut_out        (dut_out),
    .vec            (vec),
    .sample         (sample),
    .expected       (expected),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_vec  (first_err_vec),
    .first_err_valid(first_err_valid),
    .pass           (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference gate from counting the ones in the vector
  function automatic int ref_gate(input logic [1:0] o, input int v);
    int ones;
    ones = 0;
    for (int b = 0; b < N_IN; b++) ones += (v >> b) & 1;
    case (o)
      2'b00:   return (ones == N_IN) ? 1 : 0;
      2'b01:   return (ones > 0) ? 1 : 0;
      2'b10:   return ones % 2;
      default: return (ones == N_IN) ? 0 : 1;
    endcase
  endfunction

  // Modes: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted, 4 random faults
  function automatic logic behave(input int v, input int m, input logic [1:0] o,
                                  input logic [NV-1:0] fm);
    int r;
    r = ref_gate(o, v);
    case (m)
      0:       return r[0];
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~r[0];
      default: return r[0] ^ fm[v];
    endcase
  endfunction

  always_comb dut_out = behave(int'(vec), mode, sweep_op, flip_mask);

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Build the expectations for a sweep, then issue the start pulse
  task automatic applyStimulus(input logic [1:0] o, input int m);
    int ec, fv, fvec;
    res_t r;
    samp_t s;
    sweep_op  = o;
    mode      = m;
    flip_mask = NV'($urandom);
    ec = 0; fv = 0; fvec = 0;
    for (int v = 0; v < NV; v++) begin
      s.v = v; s.e = ref_gate(o, v); s.ec = ec; s.fv = fv;
      samp_q.push_back(s);
      if (int'(behave(v, m, o, flip_mask)) != ref_gate(o, v)) begin
        if (ec < ERR_MAX) ec++;
        if (fv == 0) begin fv = 1; fvec = v; end
      end
    end
    r.ec = ec; r.fvec = fvec; r.fval = fv; r.pass = (ec == 0) ? 1 : 0;
    res_q.push_back(r);
    @(posedge clk); #1;
    start = 1'b1;
    op    = o;
    @(posedge clk); #1;
    start = 1'b0;
    op    = 2'($urandom);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < SWEEP_CYC + 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) checkOutput("done_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vec"}, int'(vec), 0);
    checkOutput({tag, "_sample"}, int'(sample), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err_count"}, int'(err_count), 0);
    checkOutput({tag, "_first_err_vec"}, int'(first_err_vec), 0);
    checkOutput({tag, "_first_err_valid"}, int'(first_err_valid), 0);
    checkOutput({tag, "_pass"}, int'(pass), 0);
  endtask

  // Monitor: compares every sample cycle and every sweep completion
  int   busy_cyc  = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    samp_t s;
    res_t  r;
    if (rst) begin
      busy_cyc  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (sample) begin
        if (samp_q.size() == 0) begin
          checkOutput("unexpected_sample", 1, 0);
        end else begin
          s = samp_q.pop_front();
          checkOutput("sample_vec", int'(vec), s.v);
          checkOutput("sample_expected", int'(expected), s.e);
          checkOutput("sample_err_count", int'(err_count), s.ec);
          checkOutput("sample_first_err_valid", int'(first_err_valid), s.fv);
        end
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          r = res_q.pop_front();
          checkOutput("final_err_count", int'(err_count), r.ec);
          checkOutput("final_first_err_vec", int'(first_err_vec), r.fvec);
          checkOutput("final_first_err_valid", int'(first_err_valid), r.fval);
          checkOutput("final_pass", int'(pass), r.pass);
          checkOutput("sweep_cycles", busy_cyc, SWEEP_CYC);
          checkOutput("leftover_samples", samp_q.size(), 0);
        end
        busy_cyc = 0;
      end
      done_prev = done;
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    #12;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed sweeps: clean, stuck-at, inverted (saturates), random faults
    applyStimulus(2'b00, 0); waitDone();
    applyStimulus(2'b01, 1); waitDone();
    applyStimulus(2'b10, 1); waitDone();
    applyStimulus(2'b11, 1); waitDone();
    applyStimulus(2'b00, 2); waitDone();
    applyStimulus(2'b10, 3); waitDone();
    applyStimulus(2'b01, 4); waitDone();

    // A start pulsed mid-sweep with another op must be ignored
    applyStimulus(2'b11, 0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();

    // Reset mid-sweep aborts everything asynchronously
    applyStimulus(2'b01, 1);
    n = 0;
    while (vec != N_IN'(2) && n < SWEEP_CYC) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_vec2", int'(vec), 2);
    #1;
    rst = 1'b1;
    #1;
    checkAllZero("midsweep_reset");
    samp_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(2'b00, 0); waitDone();

    // Restart straight from DONE after a failing sweep
    applyStimulus(2'b11, 3); waitDone();
    applyStimulus(2'b11, 0); waitDone();

    // Randomized sweeps
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'($urandom), int'($urandom_range(0, 4)));
      waitDone();
    end

    checkOutput("final_queue_empty", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
